chan_text_writer: RTL
=====================

Name: chan_text_writer

Overview:
- Sequences updates of the on-screen character buffer that the text-rectangle renderer reads through its char address and line outputs.
- Accepts one channel measurement per request (channel index + millivolt value) and converts the value to ASCII with a sequential double-dabble.
- Writes one 13-character row per channel ("CHnn d.dddV  ") into the char RAM write port, only during vertical blanking, so the display read port never contends with writes.

Parameters:
- NUM_CH, 13, number of valid channels; req_ch >= NUM_CH is rejected.
- ROW_CHARS, 13, characters per text row (104 px / 8 px).
- BASE_ADDR, 0, char RAM address of row 0, column 0.

Ports:
- pclk  in  1  pixel clock.
- rst  in  1  reset.
- vblnk  in  1  vertical blank from timing chain; writes allowed only while high.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_ch  in  4  channel index, 0..NUM_CH-1.
- req_mv  in  14  value in mV, 0..16383.
- wr_en  out  1  char RAM write strobe.
- wr_addr  out  8  char RAM write address.
- wr_data  out  8  ASCII byte.
- busy  out  1  high while state != IDLE.
- err  out  1  one-cycle pulse on an invalid-channel request.

Behaviour:
- Reset: rst is synchronous, active-high; clock is pclk. While rst is high: state=IDLE, wr_en=0, wr_addr=0, wr_data=0, err=0, busy=0, req_ready=0. req_ready goes high the first cycle after rst deasserts.
- req_ready = (state==IDLE) & ~rst, combinational from state. Handshake completes on the pclk edge where req_valid & req_ready; req_ch and req_mv are captured on that edge.
- States: IDLE, CONV, WRITE.
- IDLE, accepted request, invalid channel (req_ch >= NUM_CH): err=1 for exactly one cycle, state stays IDLE, no writes.
- IDLE, accepted request, valid channel: clamp the value to 9999 when req_mv > 9999. Load the 14-bit shift register, clear the 16-bit BCD register, go to CONV with iteration count 0.
- CONV: one double-dabble iteration per cycle. Each BCD nibble >= 5 gets +3, then {bcd,bin} shifts left by 1. Exactly 14 cycles, then WRITE with col=0. Channel digits are (ch/10, ch%10), computed combinationally from the captured ch.
- WRITE: on each edge with vblnk=1, register wr_en=1, wr_addr = BASE_ADDR + ch*ROW_CHARS + col (mod 256), wr_data = char[col], then col++.
- WRITE: on each edge with vblnk=0, wr_en=0 and col holds. This pauses the row and resumes at the next blank, with no restart and no skipped or repeated column.
- WRITE: after issuing col = ROW_CHARS-1, go to IDLE. The last write strobe is visible in the first IDLE cycle.
- char[0..12] = 'C','H', 0x30+ch_tens, 0x30+ch_ones, ' ', 0x30+d3, '.', 0x30+d2, 0x30+d1, 0x30+d0, 'V', ' ', ' '. Here d3 is the thousands digit.
- Outside WRITE, wr_en=0. wr_addr and wr_data hold their last values.
- Latency with vblnk held high: accept edge E0, CONV on E1..E14, writes registered on E15..E27, req_ready high again after E27. Minimum 28 cycles between accepted requests.
- While busy, req_valid is ignored; the requester must hold its request.
- rst mid-CONV or mid-WRITE aborts immediately: wr_en=0 on the next cycle and the partial row is not completed.
- vblnk toggling during CONV has no effect.

Test Plan:
- Reset then idle: rst high for 3 cycles -> wr_en=0, busy=0, req_ready=0; req_ready=1 one cycle after release.
- ch=3, mv=1234, vblnk=1 -> 13 consecutive writes starting 15 cycles after accept. Addresses 39..51, data 43 48 30 33 20 31 2E 32 33 34 56 20 20. busy falls after the last write.
- ch=12, mv=12000 (clamp), vblnk=1 -> addresses 156..168; bytes 2..9 = 31 32 20 39 2E 39 39 39.
- ch=0, mv=5, vblnk drops after 4 writes and returns 100 cycles later -> no writes while low; writes resume at address 4 with byte 0x20, then 30 2E 30 30 35 56 20 20. Exactly 13 writes total.
- ch=13 -> err pulse of 1 cycle, no wr_en, req_ready stays 1. Then ch=1, mv=0 with req_valid held during busy -> second request accepted only after the first row completes.
- rst asserted at the 6th write -> wr_en=0 next cycle. A new request after release rewrites the full row from col 0.

Source files
------------

// File: rtl/chan_text_writer.sv
// Formats one channel measurement as a 13-character "CHnn d.dddV  " row and
// writes it into the char RAM during vertical blanking only.
module chan_text_writer #(
    parameter int         NUM_CH    = 13,
    parameter int         ROW_CHARS = 13,
    parameter logic [7:0] BASE_ADDR = 8'd0
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vblnk,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_ch,
    input  logic [13:0] req_mv,
    output logic        wr_en,
    output logic [7:0]  wr_addr,
    output logic [7:0]  wr_data,
    output logic        busy,
    output logic        err
);

    // state   | meaning
    // IDLE    | waiting for a request
    // CONV    | 14 double-dabble iterations, one per cycle
    // WRITE   | one char per blanking cycle, col 0..ROW_CHARS-1
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_CONV  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]  state;
    logic [3:0]  ch_q;
    logic [13:0] bin;
    logic [15:0] bcd;
    logic [15:0] bcd_adj;
    logic [3:0]  iter_cnt;
    logic [3:0]  col;
    logic [3:0]  ch_tens;
    logic [3:0]  ch_ones;
    logic [7:0]  char_sel;
    logic [7:0]  addr_next;
    logic        ch_bad;
    logic [13:0] mv_clamped;

    assign req_ready  = (state == S_IDLE) & ~rst;
    assign busy       = (state != S_IDLE);
    assign ch_bad     = int'(req_ch) >= NUM_CH;
    assign mv_clamped = (req_mv > 14'd9999) ? 14'd9999 : req_mv;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    // Channel index never exceeds 15, so the tens digit is 0 or 1.
    assign ch_tens = (ch_q >= 4'd10) ? 4'd1 : 4'd0;
    assign ch_ones = (ch_q >= 4'd10) ? ch_q - 4'd10 : ch_q;

    assign addr_next = 8'(int'(BASE_ADDR) + int'(ch_q) * ROW_CHARS + int'(col));

    always_comb begin
        char_sel = 8'h20;
        case (col)
            4'd0:    char_sel = 8'h43;
            4'd1:    char_sel = 8'h48;
            4'd2:    char_sel = {4'h3, ch_tens};
            4'd3:    char_sel = {4'h3, ch_ones};
            4'd4:    char_sel = 8'h20;
            4'd5:    char_sel = {4'h3, bcd[15:12]};
            4'd6:    char_sel = 8'h2E;
            4'd7:    char_sel = {4'h3, bcd[11:8]};
            4'd8:    char_sel = {4'h3, bcd[7:4]};
            4'd9:    char_sel = {4'h3, bcd[3:0]};
            4'd10:   char_sel = 8'h56;
            default: char_sel = 8'h20;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state    <= S_IDLE;
            wr_en    <= 1'b0;
            wr_addr  <= 8'd0;
            wr_data  <= 8'd0;
            err      <= 1'b0;
            ch_q     <= 4'd0;
            bin      <= 14'd0;
            bcd      <= 16'd0;
            iter_cnt <= 4'd0;
            col      <= 4'd0;
        end else begin
            wr_en <= 1'b0;
            err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        if (ch_bad) begin
                            err <= 1'b1;
                        end else begin
                            ch_q     <= req_ch;
                            bin      <= mv_clamped;
                            bcd      <= 16'd0;
                            iter_cnt <= 4'd13;
                            state    <= S_CONV;
                        end
                    end
                end
                S_CONV: begin
                    {bcd, bin} <= {bcd_adj, bin} << 1;
                    if (iter_cnt == 4'd0) begin
                        col   <= 4'd0;
                        state <= S_WRITE;
                    end else begin
                        iter_cnt <= iter_cnt - 4'd1;
                    end
                end
                S_WRITE: begin
                    if (vblnk) begin
                        wr_en   <= 1'b1;
                        wr_addr <= addr_next;
                        wr_data <= char_sel;
                        if (col == 4'(ROW_CHARS - 1))
                            state <= S_IDLE;
                        else
                            col <= col + 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
